mp_add_sequencer: RTL
=====================

// Module: mp_add_sequencer
// PURPOSE
//  Multi-cycle controller for wide additions on one WORD_W-bit carry-increment adder.
//  Takes an NWORDS*WORD_W-bit A+B+cin job over a valid/ready handshake.
//  Feeds one WORD_W slice per cycle, LSW first, to a single carry_increment_32bits instance.
//  Chains carry through a register; returns the full sum and carry-out over valid/ready.
// PARAMETERS
//  WORD_W   32  slice width; must equal adder WIDTH
//  NWORDS   4   slices per operand (>=2); operand width = NWORDS*WORD_W
// PORTS
//  clk        in   1               single clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               job request
//  in_ready   out  1               job accepted when in_valid&in_ready
//  in_a       in   NWORDS*WORD_W   operand A
//  in_b       in   NWORDS*WORD_W   operand B
//  in_cin     in   1               carry-in to LS slice
//  in_sub     in   1               present only with MP_ADD_SUB_EN; 1 = A-B
//  out_valid  out  1               result available
//  out_ready  in   1               result consumed when out_valid&out_ready
//  out_sum    out  NWORDS*WORD_W   result
//  out_cout   out  1               carry-out of MS slice
//  busy       out  1               1 in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, A/B/sum regs=0.
//   Outputs: in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
//   Reset mid-job aborts it silently; no partial result is ever presented.
//  FSM IDLE->RUN->DONE->IDLE.
//   IDLE: in_ready=1. On accept, latch in_a/in_b, carry<=in_cin, idx<=0, go RUN.
//   RUN: in_ready=0. Adder gets A[idx], B[idx], Cin=carry. Each cycle sum[idx]<=S, carry<=Cout, idx++.
//    When idx==NWORDS-1: out_cout<=Cout, go DONE.
//   DONE: out_valid=1. out_sum/out_cout held stable until out_ready=1, then go IDLE.
//  Timing: accept edge at cycle 0 -> out_valid high after edge NWORDS.
//   Throughput is one job per NWORDS+2 cycles when out_ready is tied high.
//  No overlap: in_valid is ignored outside IDLE; in_a/in_b may change freely after accept.
//  Arithmetic is modulo 2^(NWORDS*WORD_W); out_cout is the true carry from the MS slice.
//  idx is $clog2(NWORDS) bits and never wraps: RUN exits at NWORDS-1.
//  out_ready while out_valid=0 has no effect.
// CONFIGURATION
//  MP_ADD_SUB_EN defined: in_sub port exists.
//   On accept with in_sub=1: B latched as ~in_b, carry<=1, in_cin ignored.
//   out_cout=1 means no borrow (A>=B unsigned).
//  MP_ADD_SUB_EN undefined: no in_sub port; addition only.
// STRUCTURE
//  Package mp_add_pkg: typedef enum logic[1:0] {IDLE,RUN,DONE} mp_state_e; default WORD_W/NWORDS
//   localparams; function idx_w(n) = $clog2(n).
//  Sub-module: one carry_increment_32bits instance (the shared datapath).
//   Sequencer holds FSM, idx counter, carry reg, operand/sum regs and slice muxing.
// TESTING (NWORDS=4, WORD_W=32)
//  A=all-ones(128), B=1, cin=0 -> out_sum=0, out_cout=1; out_valid exactly 4 cycles after accept.
//  A=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=0x0000_0001_0000...0000, out_cout=0.
//  Hold out_ready=0 for 5 cycles in DONE -> out_sum/out_cout stable, in_ready=0, new in_valid ignored;
//   out_ready=1 -> IDLE next cycle.
//  rst_n pulsed low while idx=2 -> out_valid=0, in_ready=1 immediately.
//   Next job A=3, B=4 -> out_sum=7, with no corruption from the aborted job.
//  MP_ADD_SUB_EN: A=5, B=7, in_sub=1 -> out_sum=2^128-2, out_cout=0; A=7, B=5 -> out_sum=2, out_cout=1.
//  Back-to-back jobs with out_ready=1, random 1000 vectors -> match A+B+cin reference model.

Source files
------------

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared state type, default sizes and index-width helper for the wide-add sequencer
package mp_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_e;

    localparam int WORD_W_DEF = 32;
    localparam int NWORDS_DEF = 4;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/carry_increment_32bits.sv
// carry_increment_32bits: carry-increment adder; each 8-bit block precomputes a+b, then is bumped by its incoming carry
module carry_increment_32bits #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int BLK = 8;
    localparam int NB  = WIDTH / BLK;

    logic [NB:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] raw;
        assign raw            = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign s[g*BLK +: BLK] = raw[BLK-1:0] + {{(BLK-1){1'b0}}, c[g]};
        assign c[g+1]         = raw[BLK] | (c[g] & (&raw[BLK-1:0]));
    end

    assign cout = c[NB];

endmodule

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: wide A+B+cin, one WORD_W slice per cycle LSW first on a shared adder; MP_ADD_SUB_EN adds in_sub (A-B)
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*WORD_W-1:0] in_a,
    input  logic [NWORDS*WORD_W-1:0] in_b,
    input  logic                     in_cin,
`ifdef MP_ADD_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NWORDS*WORD_W-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int OW = NWORDS * WORD_W;
    localparam int IW = idx_w(NWORDS);

    mp_state_e         state, state_nx;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [OW-1:0]     a_r, b_r, sum_r;
    logic [WORD_W-1:0] s;
    logic              co, last, accept, sub;

`ifdef MP_ADD_SUB_EN
    assign sub = in_sub;
`else
    assign sub = 1'b0;
`endif

    assign last    = idx == IW'(NWORDS - 1);
    assign accept  = in_valid & in_ready;
    assign out_sum = sum_r;

    carry_increment_32bits #(.WIDTH(WORD_W)) u_add (
        .a   (a_r[idx*WORD_W +: WORD_W]),
        .b   (b_r[idx*WORD_W +: WORD_W]),
        .cin (carry),
        .s   (s),
        .cout(co)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        if (state == IDLE && in_valid)  state_nx = RUN;
        if (state == RUN && last)       state_nx = DONE;
        if (state == DONE && out_ready) state_nx = IDLE;
    end

    // operand latch, per-slice sum write-back and carry chaining; subtraction is A + ~B + 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            out_cout <= 1'b0;
        end else if (accept) begin
            a_r   <= in_a;
            b_r   <= sub ? ~in_b : in_b;
            carry <= sub | in_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[idx*WORD_W +: WORD_W] <= s;
            carry <= co;
            idx   <= last ? idx : idx + 1'b1;
            if (last) out_cout <= co;
        end
    end

endmodule
